mmu_region_router: RTL and testbench
====================================

Name: mmu_region_router

Overview:
- Parametrised successor to the fixed-map MMU.
- Routes one core-side memory request (vproc_mem_* interface from Vicuna/Ibex) to one of NUM_REGIONS target ports, selected by a base/mask address decode.
- Returns the response to the core. Unmapped accesses and target timeouts come back as error responses.
- Sits between the core and SRAM, GPIO, timer and flash controllers. At most one transaction is in flight.

Parameters:
- NUM_REGIONS, 4: number of target ports.
- DATA_W, 32: data width. Byte-enable width is DATA_W/8.
- REGION_BASE, {32'h4000_0000, 32'h8000_0100, 32'h8000_0000, 32'h0000_0000}: packed per-region base addresses. Region 0 is the LSB word.
- REGION_MASK, {32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000}: packed per-region compare masks.
- TIMEOUT_CYCLES, 255: maximum wait cycles for a target response. A value of 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- vproc_mem_req_o  in  1  core request valid
- vproc_mem_addr_o  in  32  byte address
- vproc_mem_we_o  in  1  1 = write, 0 = read
- vproc_mem_be_o  in  DATA_W/8  byte enables
- vproc_mem_wdata_o  in  DATA_W  write data
- vproc_mem_gnt_i  out  1  request accepted this cycle
- vproc_mem_rvalid_i  out  1  response valid (one-cycle pulse)
- vproc_mem_err_i  out  1  response is an error (qualified by rvalid)
- vproc_mem_rdata_i  out  DATA_W  read data
- tgt_req  out  NUM_REGIONS  per-region request pulse, one-hot
- tgt_addr  out  32  offset within the region (addr & ~MASK), shared
- tgt_we  out  1  shared write enable
- tgt_be  out  DATA_W/8  shared byte enables
- tgt_wdata  out  DATA_W  shared write data
- tgt_rvalid  in  NUM_REGIONS  per-region response pulse
- tgt_rdata  in  NUM_REGIONS*DATA_W  per-region read data, packed

Behaviour:

Decode:
- Region i hits when (addr & REGION_MASK[i]) == REGION_BASE[i].
- If several regions hit, the lowest index wins.
- No hit means the access is unmapped.

States: IDLE, WAIT, ERR.

Grant:
- vproc_mem_gnt_i = vproc_mem_req_o && state == IDLE. This is combinational.
- A request is accepted only when gnt is high. Requests are ignored in WAIT and ERR; the core holds them.

IDLE, on accept:
- Mapped: the next cycle, tgt_req[sel] = 1 for exactly one cycle.
  - tgt_addr, tgt_we, tgt_be and tgt_wdata come from registers captured at accept. They stay stable until the response.
  - State goes to WAIT and the timeout counter clears to 0.
- Unmapped: state goes to ERR. No tgt_req is issued.

WAIT:
- The counter increments each cycle.
- tgt_rvalid[sel] is sampled from the cycle after the tgt_req pulse. When it is seen:
  - next cycle: vproc_mem_rvalid_i = 1, err = 0, rdata = tgt_rdata[sel] (registered; writes return rdata 0);
  - state goes to IDLE.
- If the counter reaches TIMEOUT_CYCLES with no tgt_rvalid[sel] and TIMEOUT_CYCLES != 0:
  - next cycle: rvalid = 1, err = 1, rdata = 0;
  - state goes to IDLE.
- If tgt_rvalid[sel] arrives in the same cycle the counter reaches its limit, the response wins (err = 0).
- tgt_rvalid from non-selected regions is ignored.

ERR:
- Next cycle: rvalid = 1, err = 1, rdata = 0. State goes to IDLE.
- Unmapped latency: accept at cycle N, rvalid at cycle N+1.

IDLE, stray inputs:
- Any tgt_rvalid in IDLE (for example a late response after a timeout) is dropped and never forwarded.

Back-to-back:
- gnt may assert in the same cycle rvalid is driven, because the state is already IDLE.
- Minimum mapped throughput is one transaction per 3 cycles when the target responds in 1 cycle.

Reset:
- Outputs on reset: gnt = 0 (state IDLE, but gnt still follows req), rvalid = 0, err = 0, rdata = 0, tgt_req = 0, tgt_addr/we/be/wdata = 0.
- State goes to IDLE and the counter to 0.
- Reset mid-transaction drops the transaction silently; no response is issued.

Widths:
- Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
- NUM_REGIONS = 1 must elaborate.

Test Plan:
1. Read SRAM: req, addr 0x0000_1234, we = 0 -> gnt same cycle; tgt_req = 4'b0001 next cycle with tgt_addr 0x1234; target rvalid with 0xDEADBEEF one cycle later -> core rvalid = 1, err = 0, rdata = 0xDEADBEEF the following cycle.
2. Write GPIO: addr 0x8000_0004, we = 1, be = 4'b0011, wdata 0x0000_00A5 -> tgt_req = 4'b0010, tgt_addr 0x04, tgt_be 0011, tgt_wdata 0xA5; after target rvalid -> core rvalid = 1, err = 0.
3. Unmapped: addr 0x2000_0000 -> gnt, no tgt_req ever; rvalid = 1, err = 1, rdata = 0 exactly 1 cycle after accept.
4. Timeout: TIMEOUT_CYCLES = 8, timer region (0x8000_0100) never responds -> rvalid = 1, err = 1; then a late tgt_rvalid[2] pulse produces no core rvalid.
5. Overlap and back-to-back: addr 0x8000_0100 routes to region 2, not region 1; second req held high is granted in the cycle the first rvalid pulses; a stray tgt_rvalid[3] during WAIT on region 2 is ignored.
6. Reset mid-WAIT: assert rst for 1 cycle while waiting -> all outputs 0, no rvalid; the next request completes normally.

Source files
------------

// File: rtl/mmu_region_router.sv
// Base/mask address router: one core request in flight, forwarded to a single target port.
// Mapped response returns 1 cycle after target rvalid; unmapped/timeout return an error; requests held off (gnt=0) while busy.
module mmu_region_router #(
    parameter int unsigned NUM_REGIONS    = 4,
    parameter int unsigned DATA_W         = 32,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE =
        {32'h4000_0000, 32'h8000_0100, 32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*32-1:0] REGION_MASK =
        {32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vproc_mem_req_o,
    input  logic [31:0]                   vproc_mem_addr_o,
    input  logic                          vproc_mem_we_o,
    input  logic [DATA_W/8-1:0]           vproc_mem_be_o,
    input  logic [DATA_W-1:0]             vproc_mem_wdata_o,
    output logic                          vproc_mem_gnt_i,
    output logic                          vproc_mem_rvalid_i,
    output logic                          vproc_mem_err_i,
    output logic [DATA_W-1:0]             vproc_mem_rdata_i,
    output logic [NUM_REGIONS-1:0]        tgt_req,
    output logic [31:0]                   tgt_addr,
    output logic                          tgt_we,
    output logic [DATA_W/8-1:0]           tgt_be,
    output logic [DATA_W-1:0]             tgt_wdata,
    input  logic [NUM_REGIONS-1:0]        tgt_rvalid,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_REGIONS-1:0]  tgt_req_q, tgt_req_d;
    logic [31:0]             tgt_addr_q, tgt_addr_d;
    logic                    tgt_we_q, tgt_we_d;
    logic [BE_W-1:0]         tgt_be_q, tgt_be_d;
    logic [DATA_W-1:0]       tgt_wdata_q, tgt_wdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    logic                    hit;
    logic [SEL_W-1:0]        hit_idx;
    logic [NUM_REGIONS-1:0]  hit_onehot;
    logic [31:0]             hit_mask;
    logic                    sel_rvalid;
    logic [DATA_W-1:0]       sel_rdata;

    assign vproc_mem_gnt_i = vproc_mem_req_o && (state_q == IDLE);

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        hit_mask   = '0;
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            if ((vproc_mem_addr_o & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]) begin
                hit           = 1'b1;
                hit_idx       = SEL_W'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_mask      = REGION_MASK[i*32 +: 32];
            end
        end
    end

    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_rvalid = tgt_rvalid[i];
                sel_rdata  = tgt_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        tgt_req_d   = '0;
        tgt_addr_d  = tgt_addr_q;
        tgt_we_d    = tgt_we_q;
        tgt_be_d    = tgt_be_q;
        tgt_wdata_d = tgt_wdata_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        case (state_q)
            IDLE: begin
                if (vproc_mem_gnt_i) begin
                    if (hit) begin
                        state_d     = WAIT;
                        cnt_d       = '0;
                        sel_d       = hit_idx;
                        tgt_req_d   = hit_onehot;
                        tgt_addr_d  = vproc_mem_addr_o & ~hit_mask;
                        tgt_we_d    = vproc_mem_we_o;
                        tgt_be_d    = vproc_mem_be_o;
                        tgt_wdata_d = vproc_mem_wdata_o;
                    end else begin
                        state_d  = ERR;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // The target cannot answer in the cycle its request pulse is on the wire.
                if (!(|tgt_req_q) && sel_rvalid) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = tgt_we_q ? '0 : sel_rdata;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT)) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            tgt_req_q   <= '0;
            tgt_addr_q  <= '0;
            tgt_we_q    <= 1'b0;
            tgt_be_q    <= '0;
            tgt_wdata_q <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            tgt_req_q   <= tgt_req_d;
            tgt_addr_q  <= tgt_addr_d;
            tgt_we_q    <= tgt_we_d;
            tgt_be_q    <= tgt_be_d;
            tgt_wdata_q <= tgt_wdata_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign vproc_mem_rvalid_i = rvalid_q;
    assign vproc_mem_err_i    = err_q;
    assign vproc_mem_rdata_i  = rdata_q;
    assign tgt_req            = tgt_req_q;
    assign tgt_addr           = tgt_addr_q;
    assign tgt_we             = tgt_we_q;
    assign tgt_be             = tgt_be_q;
    assign tgt_wdata          = tgt_wdata_q;

endmodule

// File: tb/tb_mmu_region_router.sv
// Bench for mmu_region_router: directed transactions, expected responses queued at grant and
// compared when the core-side response pulse appears.
module tb_mmu_region_router;
    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [31:0]  addr;
    logic         we;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         gnt;
    logic         rvalid;
    logic         err;
    logic [31:0]  rdata;
    logic [3:0]   tgt_req;
    logic [31:0]  tgt_addr;
    logic         tgt_we;
    logic [3:0]   tgt_be;
    logic [31:0]  tgt_wdata;
    logic [3:0]   tgt_rvalid;
    logic [127:0] tgt_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mmu_region_router #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .vproc_mem_req_o    (req),
        .vproc_mem_addr_o   (addr),
        .vproc_mem_we_o     (we),
        .vproc_mem_be_o     (be),
        .vproc_mem_wdata_o  (wdata),
        .vproc_mem_gnt_i    (gnt),
        .vproc_mem_rvalid_i (rvalid),
        .vproc_mem_err_i    (err),
        .vproc_mem_rdata_i  (rdata),
        .tgt_req            (tgt_req),
        .tgt_addr           (tgt_addr),
        .tgt_we             (tgt_we),
        .tgt_be             (tgt_be),
        .tgt_wdata          (tgt_wdata),
        .tgt_rvalid         (tgt_rvalid),
        .tgt_rdata          (tgt_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every core response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid), 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("sb_err", 64'(err), 64'(e.err));
                check("sb_rdata", 64'(rdata), 64'(e.rdata));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the following negedge with req dropped.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic push,
                         input logic exp_err, input logic [31:0] exp_rdata);
        rsp_t e;
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        #1;
        check("gnt", 64'(gnt), 64'd1);
        if (push) begin
            e.err = exp_err; e.rdata = exp_rdata;
            sb_q.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic respond(input int idx, input logic [31:0] d);
        tgt_rvalid[idx] = 1'b1;
        tgt_rdata[idx*32 +: 32] = d;
        @(negedge clk);
        tgt_rvalid = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_rdata"}, 64'(rdata), 64'd0);
        check({tag, "_tgt_req"}, 64'(tgt_req), 64'd0);
        check({tag, "_tgt_addr"}, 64'(tgt_addr), 64'd0);
        check({tag, "_tgt_we"}, 64'(tgt_we), 64'd0);
        check({tag, "_tgt_be"}, 64'(tgt_be), 64'd0);
        check({tag, "_tgt_wdata"}, 64'(tgt_wdata), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        tgt_rvalid = '0; tgt_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check_idle_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // 1: SRAM read
        issue(32'h0000_1234, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        check("t1_tgt_req", 64'(tgt_req), 64'h1);
        check("t1_tgt_addr", 64'(tgt_addr), 64'h1234);
        check("t1_tgt_we", 64'(tgt_we), 64'd0);
        @(negedge clk);
        check("t1_req_pulse", 64'(tgt_req), 64'd0);
        respond(0, 32'hDEAD_BEEF);
        check("t1_rvalid", 64'(rvalid), 64'd1);

        // 2: GPIO write; target data must not reach the core on a write
        issue(32'h8000_0004, 1'b1, 4'b0011, 32'h0000_00A5, 1'b1, 1'b0, 32'h0);
        check("t2_tgt_req", 64'(tgt_req), 64'h2);
        check("t2_tgt_addr", 64'(tgt_addr), 64'h4);
        check("t2_tgt_we", 64'(tgt_we), 64'd1);
        check("t2_tgt_be", 64'(tgt_be), 64'h3);
        check("t2_tgt_wdata", 64'(tgt_wdata), 64'hA5);
        @(negedge clk);
        respond(1, 32'h1234_5678);
        check("t2_rvalid", 64'(rvalid), 64'd1);

        // 3: unmapped
        issue(32'h2000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0);
        check("t3_rvalid_n1", 64'(rvalid), 64'd1);
        check("t3_err", 64'(err), 64'd1);
        check("t3_no_tgt_req", 64'(tgt_req), 64'd0);
        @(negedge clk);
        check("t3_no_tgt_req2", 64'(tgt_req), 64'd0);
        check("t3_rvalid_pulse", 64'(rvalid), 64'd0);

        // 4: timer never answers -> timeout after 8 wait cycles
        issue(32'h8000_0100, 1'b0, 4'hF, 32'h0, 1'b1, 1'b1, 32'h0);
        check("t4_tgt_req", 64'(tgt_req), 64'h4);
        k = 1;
        while (rvalid !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("t4_latency", 64'(k), 64'd10);
        check("t4_err", 64'(err), 64'd1);
        respond(2, 32'hBAD0_BAD0);
        check("t4_late_dropped", 64'(rvalid), 64'd0);
        @(negedge clk);
        check("t4_late_dropped2", 64'(rvalid), 64'd0);

        // 5: 0x8000_0100 belongs to region 2; stray region-3 pulse ignored; back-to-back grant
        issue(32'h8000_0100, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        check("t5_tgt_req", 64'(tgt_req), 64'h4);
        check("t5_tgt_addr", 64'(tgt_addr), 64'h0);
        @(negedge clk);
        respond(3, 32'h1111_1111);
        check("t5_stray_ignored", 64'(rvalid), 64'd0);
        req = 1'b1; addr = 32'h0000_0010; we = 1'b0; be = 4'hF;
        #1;
        check("t5_gnt_wait", 64'(gnt), 64'd0);
        @(negedge clk);
        tgt_rvalid[2] = 1'b1;
        tgt_rdata[64 +: 32] = 32'hCAFE_F00D;
        #1;
        check("t5_gnt_wait2", 64'(gnt), 64'd0);
        @(negedge clk);
        tgt_rvalid = '0;
        #1;
        check("t5_rvalid", 64'(rvalid), 64'd1);
        check("t5_b2b_gnt", 64'(gnt), 64'd1);
        sb_q.push_back('{err: 1'b0, rdata: 32'h0BAD_CAFE});
        @(negedge clk);
        req = 1'b0;
        check("t5b_tgt_req", 64'(tgt_req), 64'h1);
        check("t5b_tgt_addr", 64'(tgt_addr), 64'h10);
        @(negedge clk);
        respond(0, 32'h0BAD_CAFE);
        check("t5b_rvalid", 64'(rvalid), 64'd1);

        // 6: reset while waiting drops the transaction silently
        issue(32'h0000_0020, 1'b1, 4'hF, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        check("t6_tgt_req", 64'(tgt_req), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t6_rst");
        rst = 1'b0;
        respond(0, 32'h7777_7777);
        check("t6_no_rvalid", 64'(rvalid), 64'd0);
        @(negedge clk);
        check("t6_no_rvalid2", 64'(rvalid), 64'd0);
        issue(32'h0000_0040, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001);
        check("t6_tgt_req2", 64'(tgt_req), 64'h1);
        check("t6_tgt_addr2", 64'(tgt_addr), 64'h40);
        @(negedge clk);
        respond(0, 32'hA5A5_0001);
        check("t6_rvalid", 64'(rvalid), 64'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
